io_page_bridge: RTL and testbench

Parametrised memory-bus splitter between the pipelined core's data port, the data RAM and a one-hot IO page of NUM_SLOTS peripherals.
- Decodes RAM vs IO from the top address bit.
- Forwards strobes to the selected peripheral slot.
- Stalls the core via mem_rbusy/mem_wbusy while a slow peripheral holds its busy line.
- Registers IO read data and muxes RAM/IO read data back to the core.

---
 rtl/io_page_bridge.sv | 128 ++++++++++++
 tb/tb_io_page_bridge.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/io_page_bridge.sv
// Splits the core data port between the data RAM and a one-hot IO page of NUM_SLOTS peripherals.
// Define IO_TIMEOUT_EN to bound peripheral wait states and enable the sticky bus_err flag.
module io_page_bridge #(
    parameter int ADDR_WIDTH     = 13,
    parameter int NUM_SLOTS      = 4,
    parameter int SLOT_LSB       = 0,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ADDR_WIDTH:0]       mem_addr,
    input  logic [31:0]               mem_wdata,
    input  logic                      mem_rstrb,
    input  logic                      mem_wstrb,
    output logic [31:0]               mem_rdata,
    output logic                      mem_rbusy,
    output logic                      mem_wbusy,
    input  logic [31:0]               ram_rdata,
    output logic                      ram_we,
    output logic [NUM_SLOTS-1:0]      per_sel,
    output logic [NUM_SLOTS-1:0]      per_rstrb,
    output logic [NUM_SLOTS-1:0]      per_wstrb,
    output logic [31:0]               per_wdata,
    input  logic [32*NUM_SLOTS-1:0]   per_rdata,
    input  logic [NUM_SLOTS-1:0]      per_busy,
    output logic                      bus_err
);

    typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} state_t;

    state_t                 state, state_nx;
    logic                   is_io, dec_ok, slot_busy, tmo, io_bad;
    logic [NUM_SLOTS-1:0]   sel_vec, slot_q;
    logic [31:0]            io_rdata, slot_rdata;
    logic                   rd_is_io_q;

    assign is_io     = mem_addr[ADDR_WIDTH];
    assign sel_vec   = mem_addr[SLOT_LSB +: NUM_SLOTS];
    assign dec_ok    = is_io && $onehot(sel_vec);
    assign per_sel   = dec_ok ? sel_vec : '0;
    assign per_wdata = mem_wdata;
    assign ram_we    = mem_wstrb & ~is_io;
    assign mem_rdata = rd_is_io_q ? io_rdata : ram_rdata;
    assign io_bad    = (state == IDLE) && (mem_rstrb || mem_wstrb) && is_io && !dec_ok;

    // slot_q is one-hot, so busy and read data reduce to AND/OR over the slots
    always_comb begin
        slot_busy  = |(per_busy & slot_q);
        slot_rdata = '0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            if (slot_q[k]) slot_rdata = slot_rdata | per_rdata[32*k +: 32];
        end
    end

`ifdef IO_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] wait_cnt;
    logic       bus_err_q;

    assign tmo     = (state != IDLE) && slot_busy && (wait_cnt == TMO_LAST);
    assign bus_err = bus_err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt  <= '0;
            bus_err_q <= 1'b0;
        end else begin
            if (state == IDLE) wait_cnt <= '0;
            else               wait_cnt <= wait_cnt + 8'd1;
            if (io_bad || tmo) bus_err_q <= 1'b1;
        end
    end
`else
    assign tmo     = 1'b0;
    assign bus_err = 1'b0;
`endif

    always_comb begin
        state_nx  = state;
        per_rstrb = '0;
        per_wstrb = '0;
        mem_rbusy = 1'b0;
        mem_wbusy = 1'b0;
        case (state)
            IDLE: begin
                // a simultaneous read is dropped in favour of the write
                if (mem_wstrb && dec_ok) begin
                    per_wstrb = sel_vec;
                    state_nx  = WR_WAIT;
                end else if (mem_rstrb && dec_ok) begin
                    per_rstrb = sel_vec;
                    state_nx  = RD_WAIT;
                end
            end
            RD_WAIT: begin
                mem_rbusy = 1'b1;
                if (!slot_busy || tmo) state_nx = IDLE;
            end
            WR_WAIT: begin
                mem_wbusy = 1'b1;
                if (!slot_busy || tmo) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            slot_q     <= '0;
            rd_is_io_q <= 1'b0;
            io_rdata   <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && (mem_rstrb || mem_wstrb) && dec_ok) slot_q <= sel_vec;
            if (state == IDLE && mem_rstrb) begin
                rd_is_io_q <= is_io;
                // an undecodable IO read returns zero
                if (is_io && !dec_ok) io_rdata <= '0;
            end
            if (state == RD_WAIT) begin
                if (tmo)             io_rdata <= 32'hDEADBEEF;
                else if (!slot_busy) io_rdata <= slot_rdata;
            end
        end
    end

endmodule

// File: tb/tb_io_page_bridge.sv
// Bench for io_page_bridge: directed cases plus randomized RAM/IO transactions checked
// against a transaction-level model (stall length, returned data, sticky error).
module tb_io_page_bridge;
    localparam int AW = 13;
    localparam int NS = 4;
    localparam int TO = 8;
`ifdef IO_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic              clk, rst;
    logic [AW:0]       mem_addr;
    logic [31:0]       mem_wdata, mem_rdata, ram_rdata, per_wdata;
    logic              mem_rstrb, mem_wstrb, mem_rbusy, mem_wbusy, ram_we, bus_err;
    logic [NS-1:0]     per_sel, per_rstrb, per_wstrb, per_busy;
    logic [32*NS-1:0]  per_rdata;

    int         checks = 0;
    int         errors = 0;
    logic       err_exp = 1'b0;
    logic [31:0] ram_m [0:255];

    io_page_bridge #(.ADDR_WIDTH(AW), .NUM_SLOTS(NS), .SLOT_LSB(0), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rstrb(mem_rstrb), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
        .mem_rbusy(mem_rbusy), .mem_wbusy(mem_wbusy), .ram_rdata(ram_rdata),
        .ram_we(ram_we), .per_sel(per_sel), .per_rstrb(per_rstrb), .per_wstrb(per_wstrb),
        .per_wdata(per_wdata), .per_rdata(per_rdata), .per_busy(per_busy), .bus_err(bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [AW:0] io_addr(input logic [NS-1:0] sel);
        logic [AW:0] a;
        a = {1'b1, AW'($urandom)};
        a[NS-1:0] = sel;
        return a;
    endfunction

    task automatic ram_txn(input bit wr, input int a, input logic [31:0] data);
        @(posedge clk); #1;
        mem_addr = {1'b0, AW'(a)};
        mem_wdata = data;
        mem_wstrb = wr;
        mem_rstrb = !wr;
        #2;
        chk("ram_we_strobe", 32'(ram_we), 32'(wr));
        chk("ram_no_per_strobe", 32'(per_rstrb | per_wstrb), 32'd0);
        if (wr) ram_m[a] = data;
        @(posedge clk); #1;
        mem_wstrb = 1'b0;
        mem_rstrb = 1'b0;
        ram_rdata = ram_m[a];
        #2;
        chk("ram_we_after", 32'(ram_we), 32'd0);
        chk("ram_no_busy", 32'({mem_rbusy, mem_wbusy}), 32'd0);
        if (!wr) chk("ram_rdata", mem_rdata, ram_m[a]);
    endtask

    // busy_cycles: per_busy of the target slot stays high for that many cycles after the strobe
    task automatic io_txn(input bit wr, input int slot, input int busy_cycles, input logic [31:0] data);
        logic [NS-1:0] oh;
        int i, stall, exp_stall, guard;
        bit timed;
        oh = NS'(1) << slot;
        @(posedge clk); #1;
        mem_addr = io_addr(oh);
        mem_wdata = $urandom;
        mem_wstrb = wr;
        mem_rstrb = !wr;
        per_busy = '0;
        per_rdata = {$urandom, $urandom, $urandom, $urandom};
        per_rdata[32*slot +: 32] = data;
        #2;
        chk("io_strobe", 32'(wr ? per_wstrb : per_rstrb), 32'(oh));
        chk("io_other_strobe", 32'(wr ? per_rstrb : per_wstrb), 32'd0);
        chk("io_per_sel", 32'(per_sel), 32'(oh));
        chk("io_ram_we", 32'(ram_we), 32'd0);
        @(posedge clk); #1;
        mem_wstrb = 1'b0;
        mem_rstrb = 1'b0;
        i = 1; stall = 0; guard = 0;
        while (guard < 300) begin
            per_busy = NS'($urandom);
            per_busy[slot] = (i <= busy_cycles);
            #2;
            if (wr ? mem_wbusy : mem_rbusy) begin
                stall++;
                if (stall == 1) chk("io_strobe_one_cycle", 32'(per_rstrb | per_wstrb), 32'd0);
                @(posedge clk); #1;
                i++;
                guard++;
            end else begin
                guard = 1000;
            end
        end
        exp_stall = busy_cycles + 1;
        timed = 1'b0;
        if (TMO_EN && busy_cycles >= TO) begin
            exp_stall = TO;
            timed = 1'b1;
            err_exp = 1'b1;
        end
        chk(wr ? "io_wr_stall" : "io_rd_stall", 32'(stall), 32'(exp_stall));
        if (!wr) chk("io_rdata", mem_rdata, timed ? 32'hDEADBEEF : data);
        chk("bus_err", 32'(bus_err), 32'(err_exp));
        per_busy = '0;
    endtask

    initial begin
        for (int k = 0; k < 256; k++) ram_m[k] = $urandom;
        rst = 1'b0;
        mem_addr = '0; mem_wdata = '0; mem_rstrb = 1'b0; mem_wstrb = 1'b0;
        ram_rdata = 32'h1111_2222; per_rdata = '0; per_busy = '0;
        #12;
        chk("rst_rbusy", 32'(mem_rbusy), 32'd0);
        chk("rst_wbusy", 32'(mem_wbusy), 32'd0);
        chk("rst_bus_err", 32'(bus_err), 32'd0);
        chk("rst_strobes", 32'({per_rstrb, per_wstrb, ram_we}), 32'd0);
        chk("rst_rdata_mux", mem_rdata, 32'h1111_2222);
        @(posedge clk); #1;
        rst = 1'b1;

        // RAM write then read
        ram_txn(1'b1, 16, 32'h12345678);
        ram_txn(1'b0, 16, 32'h0);
        chk("ram_readback", mem_rdata, 32'h12345678);

        // IO read slot 2 busy 3 cycles, IO write slot 0 not busy
        io_txn(1'b0, 2, 3, 32'hA5A5A5A5);
        io_txn(1'b1, 0, 0, 32'h0);

        // simultaneous read+write to slot 1, then a strobe during WR_WAIT
        @(posedge clk); #1;
        mem_addr = io_addr(4'b0010);
        mem_rstrb = 1'b1; mem_wstrb = 1'b1;
        #2;
        chk("both_wstrb", 32'(per_wstrb), 32'h2);
        chk("both_rstrb", 32'(per_rstrb), 32'h0);
        @(posedge clk); #1;
        per_busy = 4'b0010;
        #2;
        chk("wait_strobe_ignored", 32'({per_rstrb, per_wstrb}), 32'd0);
        chk("wait_wbusy", 32'({mem_rbusy, mem_wbusy}), 32'd1);
        @(posedge clk); #1;
        mem_rstrb = 1'b0; mem_wstrb = 1'b0; per_busy = '0;
        #2;
        chk("wait_wbusy2", 32'(mem_wbusy), 32'd1);
        @(posedge clk); #3;
        chk("wait_done", 32'({mem_rbusy, mem_wbusy, per_rstrb, per_wstrb}), 32'd0);

        // invalid one-hot decode
        @(posedge clk); #1;
        mem_addr = io_addr(4'b0110);
        mem_rstrb = 1'b1;
        #2;
        chk("bad_no_rstrb", 32'({per_rstrb, per_wstrb}), 32'd0);
        chk("bad_per_sel", 32'(per_sel), 32'd0);
        @(posedge clk); #1;
        mem_rstrb = 1'b0;
        mem_wstrb = 1'b1;
        ram_rdata = $urandom;
        err_exp = TMO_EN;
        #2;
        chk("bad_rbusy", 32'(mem_rbusy), 32'd0);
        chk("bad_rdata_zero", mem_rdata, 32'd0);
        chk("bad_no_wstrb", 32'({per_wstrb, ram_we}), 32'd0);
        @(posedge clk); #1;
        mem_wstrb = 1'b0;
        #2;
        chk("bad_wbusy", 32'(mem_wbusy), 32'd0);
        chk("bad_bus_err", 32'(bus_err), 32'(err_exp));

        // slot 3 stuck busy: times out only when the timeout feature is present
        io_txn(1'b0, 3, TMO_EN ? 1000 : 5, 32'h3C3C3C3C);

        // randomized mix of RAM and IO transactions
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 3))
                0: ram_txn(1'b1, $urandom_range(0, 255), $urandom);
                1: ram_txn(1'b0, $urandom_range(0, 255), 32'h0);
                2: io_txn(1'b0, $urandom_range(0, NS-1), $urandom_range(0, 10), $urandom);
                default: io_txn(1'b1, $urandom_range(0, NS-1), $urandom_range(0, 10), 32'h0);
            endcase
        end

        // reset in the middle of a read wait
        @(posedge clk); #1;
        mem_addr = io_addr(4'b1000);
        mem_rstrb = 1'b1;
        @(posedge clk); #1;
        mem_rstrb = 1'b0;
        per_busy = 4'b1000;
        repeat (3) begin
            #2;
            chk("mid_rbusy", 32'(mem_rbusy), 32'd1);
            @(posedge clk); #1;
        end
        ram_rdata = 32'h0;
        #1;
        rst = 1'b0;
        err_exp = 1'b0;
        #1;
        chk("mid_rst_busy", 32'({mem_rbusy, mem_wbusy}), 32'd0);
        chk("mid_rst_strobes", 32'({per_rstrb, per_wstrb, ram_we}), 32'd0);
        chk("mid_rst_bus_err", 32'(bus_err), 32'd0);
        chk("mid_rst_rdata", mem_rdata, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        per_busy = '0;
        @(posedge clk); #3;
        chk("post_rst_idle", 32'({mem_rbusy, mem_wbusy, per_rstrb, per_wstrb}), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
